// File: rtl/sevenseg_scan_driver.sv
// Multiplexed 7-segment driver following a one-hot ring counter, with per-step blanking
// and a double-buffered display value. Optional macro: LEADING_ZERO_BLANK_EN.
module sevenseg_scan_driver #(
    parameter int digits_p       = 4,
    parameter int blank_cycles_p = 1200
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [digits_p-1:0]   ring_i,
    input  logic [4*digits_p-1:0] value_i,
    input  logic [digits_p-1:0]   dp_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [6:0]            seg_o,
    output logic                  dp_o,
    output logic [digits_p-1:0]   an_o
);

    localparam int CNT_W = (blank_cycles_p > 0) ? $clog2(blank_cycles_p + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((blank_cycles_p > 0) ? blank_cycles_p - 1 : 0);
    localparam logic [digits_p-1:0] RING_FIRST = digits_p'(1);

    typedef enum logic [1:0] {ST_IDLE, ST_BLANK, ST_SHOW} state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [digits_p-1:0]   r_ringQ;
    logic [4*digits_p-1:0] r_activeVal;
    logic [digits_p-1:0]   r_activeDp;
    logic [4*digits_p-1:0] r_pendVal;
    logic [digits_p-1:0]   r_pendDp;
    logic                  r_pending;
    logic [6:0]            r_seg;
    logic                  r_dp;
    logic [digits_p-1:0]   r_an;

    state_t                w_stateNext;
    logic [CNT_W-1:0]      w_cntNext;
    logic                  w_oneHot;
    logic                  w_step;
    logic                  w_frame;
    logic                  w_accept;
    logic [4*digits_p-1:0] w_activeValNext;
    logic [digits_p-1:0]   w_activeDpNext;
    logic [3:0]            w_nib;
    logic                  w_dpSel;
    logic                  w_lzBlank;
    logic [6:0]            w_segNext;
    logic                  w_dpNext;
    logic [digits_p-1:0]   w_anNext;

    function automatic logic [6:0] hexTo7Seg(input logic [3:0] nib);
        logic [6:0] seg;
        seg = 7'b0000000;
        case (nib)
            4'h0: seg = 7'b0111111;
            4'h1: seg = 7'b0000110;
            4'h2: seg = 7'b1011011;
            4'h3: seg = 7'b1001111;
            4'h4: seg = 7'b1100110;
            4'h5: seg = 7'b1101101;
            4'h6: seg = 7'b1111101;
            4'h7: seg = 7'b0000111;
            4'h8: seg = 7'b1111111;
            4'h9: seg = 7'b1101111;
            4'hA: seg = 7'b1110111;
            4'hB: seg = 7'b1111100;
            4'hC: seg = 7'b0111001;
            4'hD: seg = 7'b1011110;
            4'hE: seg = 7'b1111001;
            4'hF: seg = 7'b1110001;
            default: seg = 7'b0000000;
        endcase
        return seg;
    endfunction

    assign w_oneHot = $onehot(ring_i);
    assign w_step   = (ring_i != r_ringQ);
    assign w_frame  = w_step && (ring_i == RING_FIRST);
    assign w_accept = valid_i && !r_pending;
    assign ready_o  = !r_pending;

    // Decode from the value that will be active after this edge so a promotion never shows stale data.
    assign w_activeValNext = (w_frame && r_pending) ? r_pendVal : r_activeVal;
    assign w_activeDpNext  = (w_frame && r_pending) ? r_pendDp  : r_activeDp;

    always_comb begin : digitSelect
        logic allZero;
        w_nib     = 4'h0;
        w_dpSel   = 1'b0;
        w_lzBlank = 1'b0;
        allZero   = 1'b1;
        for (int k = digits_p - 1; k >= 0; k--) begin
`ifdef LEADING_ZERO_BLANK_EN
            allZero = allZero && (w_activeValNext[4*k +: 4] == 4'h0);
`endif
            if (ring_i[k]) begin
                w_nib   = w_activeValNext[4*k +: 4];
                w_dpSel = w_activeDpNext[k];
`ifdef LEADING_ZERO_BLANK_EN
                w_lzBlank = allZero && (k > 0);
`else
                w_lzBlank = 1'b0;
`endif
            end
        end
    end

    always_comb begin : nextState
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        if (!w_oneHot) begin
            w_stateNext = ST_IDLE;
            w_cntNext   = '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_SHOW: begin
                    if (w_step) begin
                        w_stateNext = (blank_cycles_p == 0) ? ST_SHOW : ST_BLANK;
                        w_cntNext   = '0;
                    end
                end
                ST_BLANK: begin
                    if (w_step) begin
                        w_cntNext = '0;
                    end else if (r_cnt == CNT_LAST) begin
                        w_stateNext = ST_SHOW;
                    end else begin
                        w_cntNext = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_stateNext = ST_IDLE;
                    w_cntNext   = '0;
                end
            endcase
        end
    end

    always_comb begin : nextOutputs
        w_segNext = 7'b0000000;
        w_dpNext  = 1'b0;
        w_anNext  = '0;
        if (w_stateNext == ST_SHOW) begin
            w_anNext  = ring_i;
            w_segNext = w_lzBlank ? 7'b0000000 : hexTo7Seg(w_nib);
            w_dpNext  = w_dpSel;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_ringQ     <= '0;
            r_activeVal <= '0;
            r_activeDp  <= '0;
            r_pendVal   <= '0;
            r_pendDp    <= '0;
            r_pending   <= 1'b0;
            r_seg       <= 7'b0000000;
            r_dp        <= 1'b0;
            r_an        <= '0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
            r_ringQ <= ring_i;
            r_seg   <= w_segNext;
            r_dp    <= w_dpNext;
            r_an    <= w_anNext;
            // An accept can only happen while nothing is pending, so it never collides with a promotion.
            if (w_frame && r_pending) begin
                r_activeVal <= r_pendVal;
                r_activeDp  <= r_pendDp;
                r_pending   <= 1'b0;
            end else if (w_accept) begin
                r_pendVal <= value_i;
                r_pendDp  <= dp_i;
                r_pending <= 1'b1;
            end
        end
    end

    assign seg_o = r_seg;
    assign dp_o  = r_dp;
    assign an_o  = r_an;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Scoreboard bench for sevenseg_scan_driver: per-edge expectations from a behavioural model,
// checked by an independent negedge monitor. Honours LEADING_ZERO_BLANK_EN when defined.
module tb_sevenseg_scan_driver;

    localparam int DIG = 4;
    localparam int BC  = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [3:0]  ring_i = '0;
    logic [15:0] value_i = '0;
    logic [3:0]  dp_i = '0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [6:0]  seg_o;
    logic        dp_o;
    logic [3:0]  an_o;

    always #5 clk_i = ~clk_i;

    sevenseg_scan_driver #(.digits_p(DIG), .blank_cycles_p(BC)) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .ring_i (ring_i),
        .value_i(value_i),
        .dp_i   (dp_i),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .seg_o  (seg_o),
        .dp_o   (dp_o),
        .an_o   (an_o)
    );

    typedef struct {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
        logic       ready;
        string      tag;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    logic [6:0] segTable [16];

    int          mSince;
    bit          mArmed;
    logic [3:0]  mPrev;
    logic [15:0] mActVal, mPendVal;
    logic [3:0]  mActDp, mPendDp;
    bit          mPendFlag;

    bit          offerValid = 1'b0;
    logic [15:0] offerVal = '0;
    logic [3:0]  offerDp = '0;

    // Model of one clock edge: what the display should show right after it.
    task automatic modelEdge(input logic rst, input logic [3:0] ring, input logic valid,
                             input logic [15:0] val, input logic [3:0] dp,
                             input string tag, output bit accepted);
        exp_t e;
        bit   show, step, frame;
        int   idx;
        logic [15:0] upper;
        accepted = 1'b0;
        e.seg = 7'b0; e.dp = 1'b0; e.an = 4'b0; e.tag = tag;
        if (rst) begin
            mPrev = 4'b0; mArmed = 1'b0; mSince = 0;
            mActVal = '0; mActDp = '0; mPendVal = '0; mPendDp = '0; mPendFlag = 1'b0;
        end else begin
            step  = (ring != mPrev);
            frame = step && (ring == 4'b0001);
            if (frame && mPendFlag) begin
                mActVal = mPendVal; mActDp = mPendDp; mPendFlag = 1'b0;
            end else if (valid && !mPendFlag) begin
                mPendVal = val; mPendDp = dp; mPendFlag = 1'b1; accepted = 1'b1;
            end
            show = 1'b0;
            if ($countones(ring) != 1) begin
                mArmed = 1'b0;
            end else if (step) begin
                mArmed = 1'b1; mSince = 0; show = (BC == 0);
            end else if (mArmed) begin
                if (mSince < BC) mSince++;
                show = (mSince >= BC);
            end
            mPrev = ring;
            if (show) begin
                idx = 0;
                for (int k = 0; k < DIG; k++) if (ring[k]) idx = k;
                upper = mActVal >> (4 * idx);
                e.seg = segTable[upper[3:0]];
`ifdef LEADING_ZERO_BLANK_EN
                if (idx > 0 && upper == 16'h0) e.seg = 7'b0;
`endif
                e.dp = mActDp[idx];
                e.an = ring;
            end
        end
        e.ready = !mPendFlag;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic rst, input logic [3:0] ring, input string tag);
        bit acc;
        rst_i   = rst;
        ring_i  = ring;
        valid_i = offerValid;
        value_i = offerVal;
        dp_i    = offerDp;
        modelEdge(rst, ring, offerValid, offerVal, offerDp, tag, acc);
        @(posedge clk_i);
        #1;
        if (acc) offerValid = 1'b0;
    endtask

    task automatic scanDigit(input logic [3:0] ring, input int hold, input string tag);
        for (int c = 0; c < hold; c++) applyStimulus(1'b0, ring, tag);
    endtask

    task automatic makeOffer(input logic [15:0] val, input logic [3:0] dp);
        offerValid = 1'b1;
        offerVal   = val;
        offerDp    = dp;
    endtask

    task automatic checkOutput(input exp_t e);
        checks++;
        if (seg_o !== e.seg || dp_o !== e.dp || an_o !== e.an || ready_o !== e.ready) begin
            errors++;
            $display("[TB] FAIL %s: got seg=%b dp=%b an=%b ready=%b, want seg=%b dp=%b an=%b ready=%b",
                     e.tag, seg_o, dp_o, an_o, ready_o, e.seg, e.dp, e.an, e.ready);
        end
    endtask

    always @(negedge clk_i) begin
        if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end

    initial begin
        int pos;
        int r;
        int hold;
        logic [3:0]  ringNext;
        logic [15:0] v;

        segTable = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                     7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                     7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
                     7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};

        repeat (3) applyStimulus(1'b1, 4'b0000, "reset");
        repeat (2) applyStimulus(1'b0, 4'b0000, "postReset");

        makeOffer(16'h12A4, 4'b0010);
        scanDigit(4'b0001, 3, "load");
        scanDigit(4'b0010, 7, "frame0");
        scanDigit(4'b0100, 7, "frame0");
        scanDigit(4'b1000, 7, "frame0");
        scanDigit(4'b0001, 7, "promote12A4");
        scanDigit(4'b0010, 7, "digitA");
        scanDigit(4'b0100, 7, "digit2");
        scanDigit(4'b1000, 7, "digit1");
        scanDigit(4'b0001, 7, "digit4");

        scanDigit(4'b0010, 7, "digitA2");
        scanDigit(4'b0100, 3, "digit2pre");
        makeOffer(16'h5678, 4'b0001);
        scanDigit(4'b0100, 5, "pendingHeld");
        scanDigit(4'b1000, 7, "pendingHeld");
        scanDigit(4'b0001, 7, "promote5678");

        scanDigit(4'b0010, 7, "showBeforeBad");
        scanDigit(4'b0110, 3, "invalidRing");
        scanDigit(4'b0100, 7, "resume");

        makeOffer(16'h0070, 4'b0100);
        scanDigit(4'b1000, 7, "load0070");
        scanDigit(4'b0001, 7, "lz0");
        scanDigit(4'b0010, 7, "lz1");
        scanDigit(4'b0100, 7, "lz2");
        scanDigit(4'b1000, 7, "lz3");
        scanDigit(4'b0000, 2, "ringZero");

        makeOffer(16'h9999, 4'b1111);
        scanDigit(4'b0010, 2, "midBlankLoad");
        scanDigit(4'b0100, 2, "midBlank");
        applyStimulus(1'b1, 4'b0100, "midReset");
        scanDigit(4'b0100, 7, "afterReset");
        scanDigit(4'b1000, 7, "afterReset");
        scanDigit(4'b0001, 7, "afterResetFrame");
        scanDigit(4'b0010, 7, "afterResetFrame");

        pos = 1;
        for (int s = 0; s < 250; s++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                ringNext = 4'($urandom_range(0, 15));
            end else begin
                if (r == 1) pos = $urandom_range(0, 3);
                else pos = (pos + 1) % DIG;
                ringNext = 4'b0001 << pos;
            end
            hold = $urandom_range(1, 10);
            for (int c = 0; c < hold; c++) begin
                if (!offerValid && $urandom_range(0, 5) == 0) begin
                    v = 16'($urandom);
                    case ($urandom_range(0, 3))
                        0: v = v & 16'h00FF;
                        1: v = v & 16'h000F;
                        2: v = v & 16'h0F0F;
                        default: ;
                    endcase
                    makeOffer(v, 4'($urandom));
                end
                applyStimulus(($urandom_range(0, 199) == 0), ringNext, "random");
            end
        end

        repeat (2) @(negedge clk_i);
        #1;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d expectations left, want 0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
